psum_acc: RTL and testbench

Partial-sum accumulation stage directly upstream of `norm`. It sums `col` signed column partial sums from the MAC array over `acc_len` input beats and double-buffers the results in two banks. Each finished vector is presented to `norm` with the level-valid / completion handshake that `norm` expects. Accumulation of the next vector overlaps the division of the current one.

---
 rtl/psum_acc.sv | 197 +++++++++++++++++++
 tb/tb_psum_acc.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc.sv
// psum_acc -- partial-sum accumulation stage feeding norm.
//
// Sums COL signed column partial sums over ACC_LEN input beats into one of
// two banks, then presents each finished vector to norm with a level-valid /
// completion handshake. While norm divides the vector held in one bank, the
// other bank keeps accumulating the next one.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low; clears all state immediately
//   in         : COL column psums, column c at [BW_PSUM*(c+1)-1 : BW_PSUM*c]
//   in_valid   : in carries a beat
//   in_ready   : beat accepted on a rising edge when in_valid & in_ready
//   out        : accumulated vector, same column packing as in
//   out_valid  : level valid towards norm
//   norm_done  : 1 while norm is idle, 0 while it is dividing
//   sat        : one-cycle pulse after a beat on which any column clamped
//   dbg_state  : output FSM state register (debug visibility)
//
// Handshakes
//   Input : strict valid/ready. A beat transfers only on a rising edge where
//           in_valid & in_ready are both 1; in_ready depends on registered
//           state only. A beat offered while in_ready==0 is ignored and the
//           source must hold it.
//   Output: out_valid is a level. norm signals start by dropping norm_done
//           and completion by raising it again; out_valid then drops for at
//           least one cycle before the next vector is presented.

module psum_acc #(
  parameter int BW      = 8,
  parameter int BW_PSUM = 2*BW + 4,
  parameter int COL     = 8,
  parameter int ACC_LEN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BW_PSUM*COL-1:0] in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [BW_PSUM*COL-1:0] out,
  output logic                   out_valid,
  input  logic                   norm_done,
  output logic                   sat,
  output logic [1:0]             dbg_state
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  localparam logic signed [BW_PSUM-1:0] PSUM_MAX = {1'b0, {(BW_PSUM-1){1'b1}}};
  localparam logic signed [BW_PSUM-1:0] PSUM_MIN = {1'b1, {(BW_PSUM-1){1'b0}}};

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_st_e;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESENT   = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } out_st_e;

  // Bank storage and bookkeeping
  logic signed [BW_PSUM-1:0] bank_q [2][COL];
  logic signed [BW_PSUM-1:0] bank_d [2][COL];
  bank_st_e                  bank_st_q [2];
  bank_st_e                  bank_st_d [2];
  logic                      wr_sel_q, wr_sel_d;
  logic                      rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      sat_q, sat_d;

  // Output side
  out_st_e                   state_q, state_d;
  logic [BW_PSUM*COL-1:0]    out_q, out_d;
  logic                      release_bank;
  logic                      accept;

  assign in_ready  = (bank_st_q[wr_sel_q] != BANK_FULL);
  assign accept    = in_valid & in_ready;
  assign out       = out_q;
  assign out_valid = (state_q == S_PRESENT) || (state_q == S_WAIT_DONE);
  assign sat       = sat_q;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Output FSM: next state, output capture and bank release
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    release_bank = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bank_st_q[rd_sel_q] == BANK_FULL) begin
          state_d = S_PRESENT;
          for (int c = 0; c < COL; c++) begin
            out_d[c*BW_PSUM +: BW_PSUM] = bank_q[rd_sel_q][c];
          end
        end
      end
      S_PRESENT: begin
        if (!norm_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (norm_done) begin
          state_d      = S_GAP;
          release_bank = 1'b1;
        end
      end
      S_GAP: begin
        // One guaranteed low cycle of out_valid so norm sees a fresh edge.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rd_sel_d = rd_sel_q ^ release_bank;
  end

  // ---------------------------------------------------------------------------
  // Input side: beat accumulation with saturation
  // ---------------------------------------------------------------------------
  always_comb begin
    logic signed [BW_PSUM-1:0] in_col;
    logic        [BW_PSUM:0]   sum;
    in_col    = '0;
    sum       = '0;
    bank_d    = bank_q;
    bank_st_d = bank_st_q;
    wr_sel_d  = wr_sel_q;
    cnt_d     = cnt_q;
    sat_d     = 1'b0;

    if (accept) begin
      for (int c = 0; c < COL; c++) begin
        in_col = $signed(in[c*BW_PSUM +: BW_PSUM]);
        if (cnt_q == '0) begin
          // First beat overwrites: whatever the bank held is stale.
          bank_d[wr_sel_q][c] = in_col;
        end else begin
          sum = {bank_q[wr_sel_q][c][BW_PSUM-1], bank_q[wr_sel_q][c]}
              + {in_col[BW_PSUM-1], in_col};
          // Overflow when the extra sign bit disagrees with the result MSB;
          // the extra bit then tells the true sign of the sum.
          if (sum[BW_PSUM] != sum[BW_PSUM-1]) begin
            bank_d[wr_sel_q][c] = sum[BW_PSUM] ? PSUM_MIN : PSUM_MAX;
            sat_d               = 1'b1;
          end else begin
            bank_d[wr_sel_q][c] = sum[BW_PSUM-1:0];
          end
        end
      end

      if (cnt_q == CNT_LAST) begin
        bank_st_d[wr_sel_q] = BANK_FULL;
        wr_sel_d            = ~wr_sel_q;
        cnt_d               = '0;
      end else begin
        bank_st_d[wr_sel_q] = BANK_FILLING;
        cnt_d               = cnt_q + CNT_W'(1);
      end
    end

    // The read bank is FULL and the write bank is not FULL whenever both are
    // active, so this never collides with the FULL marking above.
    if (release_bank) bank_st_d[rd_sel_q] = BANK_EMPTY;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_q    <= '{default: '{default: '0}};
      bank_st_q <= '{default: BANK_EMPTY};
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      state_q   <= S_IDLE;
      out_q     <= '0;
    end else begin
      bank_q    <= bank_d;
      bank_st_q <= bank_st_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      state_q   <= state_d;
      out_q     <= out_d;
    end
  end

endmodule

// File: tb/tb_psum_acc.sv
module tb_psum_acc;

  localparam int BW      = 8;
  localparam int W       = 2*BW + 4;
  localparam int COL     = 8;
  localparam int ACC_LEN = 4;
  localparam int VW      = W*COL;
  localparam int PMAX    = 524287;
  localparam int PMIN    = -524288;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic [VW-1:0] in;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] out;
  logic          out_valid;
  logic          norm_done;
  logic          sat;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  psum_acc #(.BW(BW), .BW_PSUM(W), .COL(COL), .ACC_LEN(ACC_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .norm_done (norm_done),
    .sat       (sat),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard state
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_v;
  logic [VW-1:0] held_out;
  bit            have_held = 1'b0;
  bit            prev_ov   = 1'b0;
  int            pres_cnt  = 0;
  int            sat_cnt   = 0;
  int            exp_sat   = 0;
  int            stall_cnt = 0;

  // Stimulus vector currently being sent
  logic [VW-1:0] beats[ACC_LEN];

  // norm behaviour knobs
  int norm_lat   = 1;
  int norm_delay = 3;
  bit norm_stuck = 1'b0;

  // ---------------------------------------------------------------------------
  // norm model: reacts to out_valid, drops norm_done after norm_lat cycles,
  // raises it again norm_delay cycles later.
  // ---------------------------------------------------------------------------
  initial begin
    norm_done = 1'b1;
    forever begin
      @(negedge clk);
      if (norm_stuck) norm_done = 1'b0;
      else if (norm_done !== 1'b1) norm_done = 1'b1;
      else if (out_valid === 1'b1) begin
        repeat (norm_lat) @(negedge clk);
        norm_done = 1'b0;
        repeat (norm_delay) @(negedge clk);
        norm_done = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: compare each presented vector with the expected queue
  // and require out to stay stable between presentations.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    #1;
    if (reset !== 1'b1) begin
      prev_ov   = 1'b0;
      have_held = 1'b0;
    end else begin
      if (sat === 1'b1) sat_cnt++;
      if (out_valid === 1'b1 && !prev_ov) begin
        pres_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_vector actual=%h required=none", out);
        end else begin
          exp_v = exp_q.pop_front();
          if (out !== exp_v) begin
            failures++;
            $display("FAIL sb_vector actual=%h required=%h", out, exp_v);
          end
        end
        held_out  = out;
        have_held = 1'b1;
      end else if (have_held) begin
        checks++;
        if (out !== held_out) begin
          failures++;
          $display("FAIL out_stable actual=%h required=%h", out, held_out);
        end
      end
      prev_ov = (out_valid === 1'b1);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic with clamping per beat
  // ---------------------------------------------------------------------------
  function automatic void model_vector();
    int            acc[COL];
    int            v;
    bit            clamped;
    logic [VW-1:0] r;
    for (int b = 0; b < ACC_LEN; b++) begin
      clamped = 1'b0;
      for (int c = 0; c < COL; c++) begin
        v = int'($signed(beats[b][c*W +: W]));
        if (b == 0) acc[c] = v;
        else begin
          acc[c] = acc[c] + v;
          if (acc[c] > PMAX) begin acc[c] = PMAX; clamped = 1'b1; end
          if (acc[c] < PMIN) begin acc[c] = PMIN; clamped = 1'b1; end
        end
      end
      if (clamped) exp_sat++;
    end
    r = '0;
    for (int c = 0; c < COL; c++) r[c*W +: W] = W'(acc[c]);
    exp_q.push_back(r);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_beats();
    for (int b = 0; b < ACC_LEN; b++) beats[b] = '0;
  endtask

  task automatic random_beats();
    int v;
    for (int b = 0; b < ACC_LEN; b++)
      for (int c = 0; c < COL; c++) begin
        if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 2000)) - 1000;
        else v = int'($urandom);
        beats[b][c*W +: W] = W'(v);
      end
  endtask

  task automatic send_vector(input bit push_exp);
    int b     = 0;
    int guard = 0;
    if (push_exp) model_vector();
    while (b < ACC_LEN) begin
      @(negedge clk);
      in       = beats[b];
      in_valid = 1'b1;
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1 in_valid = 1'b0;
        b++;
      end else begin
        stall_cnt++;
        guard++;
        if (guard > 300) begin
          checks++;
          failures++;
          $display("FAIL send_timeout actual=in_ready_low required=accept beat=%0d", b);
          in_valid = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      sample();
      if (exp_q.size() == 0 && out_valid === 1'b0 && norm_done === 1'b1) break;
    end
    if (i == 400) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=pending%0d required=0", exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset    = 1'b0;
    in       = '0;
    in_valid = 1'b0;
    #1;
    checks += 4;
    if (out !== '0) begin failures++; $display("FAIL reset_out actual=%h required=0", out); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b required=1", in_ready); end
    if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat actual=%b required=0", sat); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) sample();
  endtask

  task automatic test_basic_sum();
    int s0;
    norm_lat   = 1;
    norm_delay = 3;
    s0 = sat_cnt;
    clear_beats();
    for (int b = 0; b < ACC_LEN; b++) begin
      beats[b][0 +: W]   = W'(b + 1);
      beats[b][7*W +: W] = W'(-5);
    end
    send_vector(1'b1);
    sample();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency_early actual=%b required=0", out_valid); end
    sample();
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency actual=%b required=1", out_valid); end
    if (out[0 +: W] !== W'(10)) begin failures++; $display("FAIL basic_col0 actual=%0d required=10", $signed(out[0 +: W])); end
    if (out[7*W +: W] !== W'(-20)) begin failures++; $display("FAIL basic_col7 actual=%0d required=-20", $signed(out[7*W +: W])); end
    wait_idle();
    checks++;
    if (sat_cnt !== s0) begin failures++; $display("FAIL basic_sat actual=%0d required=0", sat_cnt - s0); end
  endtask

  task automatic test_saturation(input bit negative);
    int s0;
    s0 = sat_cnt;
    clear_beats();
    beats[0][3*W +: W] = negative ? W'(PMIN) : W'(PMAX);
    beats[1][3*W +: W] = negative ? W'(-1) : W'(1);
    send_vector(1'b1);
    wait_idle();
    checks += 2;
    if (out[3*W +: W] !== (negative ? W'(PMIN) : W'(PMAX))) begin
      failures++;
      $display("FAIL sat_col3_neg%0d actual=%0d", negative, $signed(out[3*W +: W]));
    end
    if (sat_cnt - s0 !== 1) begin
      failures++;
      $display("FAIL sat_pulses_neg%0d actual=%0d required=1", negative, sat_cnt - s0);
    end
  endtask

  task automatic test_handshake();
    logic [VW-1:0] cap;
    int  nd_rise = -1;
    int  ov_fall = -1;
    bit  seen_low = 1'b0;
    bit  stable = 1'b1;
    int  i;
    norm_lat   = 1;
    norm_delay = 10;
    random_beats();
    send_vector(1'b1);
    for (i = 0; i < 10; i++) begin
      sample();
      if (out_valid === 1'b1) break;
    end
    checks++;
    if (i == 10) begin failures++; $display("FAIL hs_present_timeout actual=0 required=1"); end
    cap = out;
    for (int k = 0; k < 30; k++) begin
      sample();
      if (out !== cap) stable = 1'b0;
      if (norm_done === 1'b0) seen_low = 1'b1;
      if (seen_low && norm_done === 1'b1 && nd_rise < 0) nd_rise = k;
      if (out_valid === 1'b0 && ov_fall < 0) ov_fall = k;
    end
    checks += 3;
    if (nd_rise < 0 || ov_fall !== nd_rise + 1) begin
      failures++;
      $display("FAIL hs_fall_timing actual=%0d required=%0d", ov_fall, nd_rise + 1);
    end
    if (ov_fall < 0 || ov_fall < 10) begin
      failures++;
      $display("FAIL hs_held_through_div actual=%0d required>=10", ov_fall);
    end
    if (!stable) begin failures++; $display("FAIL hs_out_stable actual=changed required=held"); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    norm_lat   = 0;
    norm_delay = 1;
    stall_cnt  = 0;
    for (int v = 0; v < 5; v++) begin
      random_beats();
      send_vector(1'b1);
    end
    checks++;
    if (stall_cnt !== 0) begin failures++; $display("FAIL b2b_stalls actual=%0d required=0", stall_cnt); end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int  p0;
    int  i;
    bit  v3_done = 1'b0;
    norm_lat   = 1;
    norm_delay = 3;
    norm_stuck = 1'b1;
    p0 = pres_cnt;
    sample();
    random_beats();
    send_vector(1'b1);
    random_beats();
    send_vector(1'b1);
    sample();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_after_v2 actual=%b required=0", in_ready); end
    random_beats();
    fork
      begin
        send_vector(1'b1);
        v3_done = 1'b1;
      end
    join_none
    repeat (6) sample();
    checks += 2;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_held actual=%b required=0", in_ready); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_v1_presented actual=%b required=1", out_valid); end
    norm_stuck = 1'b0;
    for (i = 0; i < 20; i++) begin
      sample();
      if (out_valid === 1'b0) break;
    end
    checks++;
    if (i == 20 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_return actual=%b required=1", in_ready);
    end
    for (i = 0; i < 200 && !v3_done; i++) sample();
    wait_idle();
    checks++;
    if (pres_cnt - p0 !== 3) begin failures++; $display("FAIL bp_vector_count actual=%0d required=3", pres_cnt - p0); end
  endtask

  task automatic test_async_reset();
    int i;
    int p0;
    norm_lat   = 1;
    norm_delay = 30;
    random_beats();
    send_vector(1'b1);
    for (i = 0; i < 10; i++) begin
      sample();
      if (out_valid === 1'b1) break;
    end
    random_beats();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      in       = beats[b];
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    @(negedge clk);
    in       = beats[2];
    in_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (out !== '0) begin failures++; $display("FAIL arst_out actual=%h required=0", out); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid actual=%b required=0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready actual=%b required=1", in_ready); end
    if (sat !== 1'b0) begin failures++; $display("FAIL arst_sat actual=%b required=0", sat); end
    in_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (i = 0; i < 100; i++) begin
      sample();
      if (norm_done === 1'b1) break;
    end
    norm_delay = 3;
    p0 = pres_cnt;
    random_beats();
    send_vector(1'b1);
    wait_idle();
    checks++;
    if (pres_cnt - p0 !== 1) begin failures++; $display("FAIL arst_post_vectors actual=%0d required=1", pres_cnt - p0); end
  endtask

  task automatic test_random();
    int s0;
    int e0;
    s0 = sat_cnt;
    e0 = exp_sat;
    for (int v = 0; v < 10; v++) begin
      norm_lat   = int'($urandom_range(0, 1));
      norm_delay = int'($urandom_range(1, 8));
      random_beats();
      send_vector(1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    checks++;
    if (sat_cnt - s0 !== exp_sat - e0) begin
      failures++;
      $display("FAIL rand_sat_pulses actual=%0d required=%0d", sat_cnt - s0, exp_sat - e0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic_sum();
    test_saturation(1'b0);
    test_saturation(1'b1);
    test_handshake();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
